// File: rtl/alsu_cmd_seq.sv
// Command sequencer for the registered ALSU: buffers commands, issues one per cycle, collects
// results after the fixed latency into a tagged response FIFO. Optional: ALSU_CMD_SEQ_IDLE_ZERO_EN.
module alsu_cmd_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic [2:0]       cmd_opcode,
  input  logic [6:0]       cmd_ctrl,
  output logic [2:0]       alsu_A,
  output logic [2:0]       alsu_B,
  output logic [2:0]       alsu_opcode,
  output logic             alsu_cin,
  output logic             alsu_serial_in,
  output logic             alsu_red_op_A,
  output logic             alsu_red_op_B,
  output logic             alsu_bypass_A,
  output logic             alsu_bypass_B,
  output logic             alsu_direction,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  // Stage 0 tracks the command currently on the alsu_* pins; the LATENCY stages behind it follow
  // the ALSU pipeline, so the tail lines up with the cycle alsu_out holds the result.
  localparam int unsigned Stages = LATENCY + 1;
  localparam int unsigned FlW    = $clog2(Stages + 1);
  localparam int unsigned CmdW   = 16;

  typedef enum logic {StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [CmdW-1:0]  cmd_mem_q [DEPTH];
  logic [PtrW-1:0]  cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CntW-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [5:0]       rsp_dmem_q [DEPTH];
  logic [TAG_W-1:0] rsp_tmem_q [DEPTH];
  logic [PtrW-1:0]  rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [CntW-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [Stages-1:0] pipe_vld_q, pipe_vld_d;
  logic [TAG_W-1:0] pipe_tag_q [Stages];
  logic [TAG_W-1:0] pipe_tag_d [Stages];
  logic [CmdW-1:0]  alsu_q, alsu_d;
  logic [FlW-1:0]   in_flight;
  logic [31:0]      credit_used;
  logic             cmd_push, cmd_empty, cmd_full, flush_now, issue, capture, rsp_pop;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < Stages; i++) in_flight = in_flight + FlW'(pipe_vld_q[i]);
  end

  always_comb begin
    cmd_empty   = (cmd_cnt_q == '0);
    cmd_full    = (cmd_cnt_q == CntW'(DEPTH));
    cmd_ready   = (state_q == StRun) && !cmd_full;
    cmd_push    = cmd_valid && cmd_ready;
    flush_now   = (state_q == StRun) && flush;
    credit_used = 32'(in_flight) + 32'(rsp_cnt_q);
    issue       = (state_q == StRun) && !flush && !cmd_empty && (credit_used < DEPTH);
    capture     = pipe_vld_q[Stages-1];
    rsp_valid   = (rsp_cnt_q != '0);
    rsp_pop     = rsp_valid && rsp_ready;
    rsp_data    = rsp_dmem_q[rsp_rptr_q];
    rsp_tag     = rsp_tmem_q[rsp_rptr_q];
    busy        = !cmd_empty || (in_flight != '0);
  end

  always_comb begin
    cmd_wptr_d = cmd_wptr_q + PtrW'(cmd_push);
    cmd_rptr_d = cmd_rptr_q + PtrW'(issue);
    cmd_cnt_d  = cmd_cnt_q + CntW'(cmd_push) - CntW'(issue);
    // A flush also discards a command accepted on the same edge.
    if (flush_now) begin
      cmd_wptr_d = '0;
      cmd_rptr_d = '0;
      cmd_cnt_d  = '0;
    end
    rsp_wptr_d = rsp_wptr_q + PtrW'(capture);
    rsp_rptr_d = rsp_rptr_q + PtrW'(rsp_pop);
    rsp_cnt_d  = rsp_cnt_q + CntW'(capture) - CntW'(rsp_pop);
    tag_d      = tag_q + TAG_W'(issue);
    pipe_vld_d = {pipe_vld_q[Stages-2:0], issue};
    pipe_tag_d[0] = tag_q;
    for (int unsigned i = 1; i < Stages; i++) pipe_tag_d[i] = pipe_tag_q[i-1];
`ifdef ALSU_CMD_SEQ_IDLE_ZERO_EN
    alsu_d = issue ? cmd_mem_q[cmd_rptr_q] : '0;
`else
    alsu_d = issue ? cmd_mem_q[cmd_rptr_q] : alsu_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (in_flight == '0) state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_cnt_q  <= '0;
      tag_q      <= '0;
      pipe_vld_q <= '0;
      alsu_q     <= '0;
      for (int unsigned i = 0; i < Stages; i++) pipe_tag_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cmd_mem_q[i]  <= '0;
        rsp_dmem_q[i] <= '0;
        rsp_tmem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      rsp_cnt_q  <= rsp_cnt_d;
      tag_q      <= tag_d;
      pipe_vld_q <= pipe_vld_d;
      alsu_q     <= alsu_d;
      for (int unsigned i = 0; i < Stages; i++) pipe_tag_q[i] <= pipe_tag_d[i];
      if (cmd_push && !flush_now) begin
        cmd_mem_q[cmd_wptr_q] <= {cmd_a, cmd_b, cmd_opcode, cmd_ctrl};
      end
      if (capture) begin
        rsp_dmem_q[rsp_wptr_q] <= alsu_out;
        rsp_tmem_q[rsp_wptr_q] <= pipe_tag_q[Stages-1];
      end
    end
  end

  assign alsu_A         = alsu_q[15:13];
  assign alsu_B         = alsu_q[12:10];
  assign alsu_opcode    = alsu_q[9:7];
  assign alsu_direction = alsu_q[6];
  assign alsu_bypass_B  = alsu_q[5];
  assign alsu_bypass_A  = alsu_q[4];
  assign alsu_red_op_B  = alsu_q[3];
  assign alsu_red_op_A  = alsu_q[2];
  assign alsu_serial_in = alsu_q[1];
  assign alsu_cin       = alsu_q[0];

endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Directed bench for alsu_cmd_seq: a 2-stage ALSU stand-in, an in-order response scoreboard and
// hand-computed spot checks. Honours ALSU_CMD_SEQ_IDLE_ZERO_EN for idle-pin expectations.
module tb_alsu_cmd_seq;
  logic       clk = 1'b0;
  logic       rst, flush, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [2:0] cmd_a, cmd_b, cmd_opcode, alsu_A, alsu_B, alsu_opcode;
  logic [6:0] cmd_ctrl;
  logic       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic       alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0] alsu_out, rsp_data;
  logic [3:0] rsp_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [3:0] last_tag = '0;
  logic [3:0] exp_tag = '0;
  logic [5:0] exp_q[$];
  logic [5:0] alsu_s1 = '0;
  logic [5:0] alsu_s2 = '0;

  alsu_cmd_seq #(.DEPTH(4), .LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_ctrl(cmd_ctrl),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin),
    .alsu_serial_in(alsu_serial_in), .alsu_red_op_A(alsu_red_op_A),
    .alsu_red_op_B(alsu_red_op_B), .alsu_bypass_A(alsu_bypass_A),
    .alsu_bypass_B(alsu_bypass_B), .alsu_direction(alsu_direction), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Arbitrary but command-dependent result so every response is distinguishable.
  function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] op, input logic [6:0] c);
    return {a, b} ^ {op, op} ^ c[5:0] ^ 6'h37 ^ {6{c[6]}};
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    alsu_s1 <= alsu_f(alsu_A, alsu_B, alsu_opcode, {alsu_direction, alsu_bypass_B,
                      alsu_bypass_A, alsu_red_op_B, alsu_red_op_A, alsu_serial_in, alsu_cin});
    alsu_s2 <= alsu_s1;
  end
  assign alsu_out = alsu_s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: responses appear in command order with consecutive tags.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
        check("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          exp_tag  = exp_tag + 4'd1;
          last_tag = rsp_tag;
          if (rsp_seen == 0) first_cyc = cyc;
          last_cyc = cyc;
          rsp_seen++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_ctrl = '0;
    exp_q.delete(); exp_tag = '0; rsp_seen = 0;
    step(2);
    check("rst_alsu_ops", 32'({alsu_A, alsu_B, alsu_opcode}), 32'd0);
    check("rst_alsu_ctrl", 32'({alsu_direction, alsu_bypass_B, alsu_bypass_A, alsu_red_op_B,
                                alsu_red_op_A, alsu_serial_in, alsu_cin}), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp", 32'({rsp_valid, rsp_data, rsp_tag, busy}), 32'd0);
    rst = 1'b0;
    step(1);
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                      input logic [6:0] c);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_ctrl = c;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!cmd_ready) begin
      check("send_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(alsu_f(a, b, op, c));
      #1;
    end
  endtask

  task automatic send_idx(input int i);
    logic [6:0] c = 7'(i * 13);
    send(3'(i), 3'(~i), 3'(i % 6), c);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && n < 200) begin
      step(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single command
    do_reset();
    rsp_ready = 1'b1;
    send(3'd3, 3'd5, 3'd0, 7'd0);
    cmd_valid = 1'b0;
    check("t1_busy_queued", 32'(busy), 32'd1);
    check("t1_pre_issue_A", 32'(alsu_A), 32'd0);
    step(1);
    check("t1_issue_A", 32'(alsu_A), 32'd3);
    check("t1_issue_B", 32'(alsu_B), 32'd5);
    step(1);
`ifdef ALSU_CMD_SEQ_IDLE_ZERO_EN
    check("t1_idle_A", 32'({alsu_A, alsu_B}), 32'd0);
`else
    check("t1_hold_A", 32'({alsu_A, alsu_B}), 32'h1d);
`endif
    step(1);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    step(1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'h2a);
    check("t1_rsp_tag", 32'(rsp_tag), 32'd0);
    step(1);
    check("t1_idle", 32'({busy, rsp_valid}), 32'd0);
    check("t1_count", 32'(rsp_seen), 32'd1);

    // Back-to-back
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_idx(i + 1);
    cmd_valid = 1'b0;
    wait_idle("t2_drain");
    check("t2_count", 32'(rsp_seen), 32'd4);
    check("t2_spacing", 32'(last_cyc - first_cyc), 32'd3);
    check("t2_last_tag", 32'(last_tag), 32'd3);

    // Backpressure and credit
    do_reset();
    for (int i = 0; i < 8; i++) send_idx(i + 2);
    cmd_valid = 1'b0;
    step(4);
    check("t3_cmd_full", 32'(cmd_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_rsp_held", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    wait_idle("t3_drain");
    check("t3_count", 32'(rsp_seen), 32'd8);
    check("t3_last_tag", 32'(last_tag), 32'd7);

    // Tag wrap
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_idx(i);
    cmd_valid = 1'b0;
    wait_idle("t4_drain");
    check("t4_count", 32'(rsp_seen), 32'd17);
    check("t4_wrap_tag", 32'(last_tag), 32'd0);

    // Flush: third command is still queued on the flush edge
    do_reset();
    rsp_ready = 1'b1;
    send(3'd1, 3'd2, 3'd1, 7'h05);
    send(3'd6, 3'd3, 3'd2, 7'h41);
    send(3'd7, 3'd7, 3'd4, 7'h12);
    cmd_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    void'(exp_q.pop_back());
    #1;
    flush = 1'b0;
    check("t5_drain_ready", 32'(cmd_ready), 32'd0);
`ifdef ALSU_CMD_SEQ_IDLE_ZERO_EN
    check("t5_pins_after_flush", 32'(alsu_A), 32'd0);
`else
    check("t5_pins_after_flush", 32'(alsu_A), 32'd6);
`endif
    for (int n = 0; n < 20 && !cmd_ready; n++) step(1);
    check("t5_ready_back", 32'(cmd_ready), 32'd1);
    check("t5_inflight_done", 32'(busy), 32'd0);
    check("t5_count", 32'(rsp_seen), 32'd2);
    send(3'd2, 3'd4, 3'd5, 7'h7f);
    cmd_valid = 1'b0;
    wait_idle("t5_drain");
    check("t5_next_tag", 32'(last_tag), 32'd2);

    // Reset with two commands in flight
    do_reset();
    rsp_ready = 1'b1;
    send(3'd5, 3'd1, 3'd3, 7'h22);
    send(3'd4, 3'd6, 3'd1, 7'h09);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_tag = '0;
    #1;
    check("t6_rst_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_direction, alsu_cin}), 32'd0);
    check("t6_rst_rsp", 32'({rsp_valid, rsp_data, rsp_tag, busy}), 32'd0);
    check("t6_rst_ready", 32'(cmd_ready), 32'd1);
    step(1);
    rst = 1'b0;
    step(8);
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
